ps2_scancode_ctrl: RTL and testbench
====================================

// Module: ps2_scancode_ctrl
// PURPOSE
// - Sequencer between the PS/2 keyboard receiver FIFO and the game/UI logic.
// - Pops bytes over the ready/rdn handshake and folds E0/F0/E1 prefixes into one key event.
// - Discards protocol bytes, then presents each event on a valid/ready port.
// - One instance per keyboard receiver.
// PARAMETERS
// - PREFIX_TIMEOUT  2_500_000  cycles a pending prefix may wait for the next byte (50 ms @ 50 MHz)
// - PAUSE_LEN       7          bytes following E1 that form the Pause sequence
// PORTS
// - clk          in   1  system clock, 50 MHz; sole clock
// - clrn         in   1  reset, synchronous, active-low
// - kb_ready     in   1  receiver FIFO non-empty
// - kb_data      in   8  receiver FIFO head byte, valid while kb_ready
// - kb_overflow  in   1  receiver FIFO overflow flag
// - kb_rdn       out  1  pop strobe to receiver, active-low
// - evt_valid    out  1  key event available
// - evt_ready    in   1  consumer accepts event
// - evt_code     out  8  scan code (set 2, prefixes stripped)
// - evt_ext      out  1  code was E0-prefixed (Pause reports evt_ext=1)
// - evt_break    out  1  1 = key release, 0 = key press
// - err_sticky   out  1  overflow seen or 00/FF error byte received; cleared only by reset
// BEHAVIOUR
// - Reset values: kb_rdn=1, evt_valid=0, evt_code=0, evt_ext=0, evt_break=0, err_sticky=0.
// - Reset internals: ext_f=0, brk_f=0, skip_cnt=0, timer=0, state=IDLE.
// - Reset takes priority in any state; an event in flight is dropped; kb_rdn returns high the next cycle.
// - All outputs are registered.
// - IDLE: if kb_ready and evt_valid==0: byte_q<=kb_data, kb_rdn<=0, go to POP.
// - POP: kb_rdn<=1 (low exactly 1 cycle, so 1 byte popped), go to GAP.
// - GAP: one dead cycle so kb_ready reflects the new r_ptr; go to DECODE.
// - DECODE, when skip_cnt!=0: skip_cnt--.
//   - If the result is 0: load event code=77, ext=1, break=0; go to EMIT.
//   - Otherwise go to IDLE.
// - DECODE, by byte value:
//   - E0: ext_f<=1; go to IDLE.
//   - F0: brk_f<=1; go to IDLE.
//   - E1: skip_cnt<=PAUSE_LEN; clear flags; go to IDLE.
//   - AA/FA/EE/FE (BAT/ack/echo/resend): drop; clear flags; go to IDLE.
//   - 00/FF: drop; clear flags; err_sticky<=1; go to IDLE.
//   - Any other byte: evt_code<=byte, evt_ext<=ext_f, evt_break<=brk_f, evt_valid<=1; clear flags; go to EMIT.
// - EMIT: hold evt_* stable while evt_valid && !evt_ready.
// - EMIT handshake: on evt_valid && evt_ready, evt_valid<=0 next cycle; go to IDLE.
// - No new pop occurs while evt_valid=1; the receiver FIFO provides buffering.
// - Latency: kb_ready sampled high at cycle N with a code byte -> evt_valid high at N+4.
// - Throughput: at most 1 byte per 4 cycles.
// - Prefix timeout:
//   - timer runs while (ext_f|brk_f) and state==IDLE and !kb_ready.
//   - Any pop resets timer.
//   - At PREFIX_TIMEOUT-1, flags clear and timer=0.
// - Overflow: on a kb_overflow rising edge, clear ext_f, brk_f and skip_cnt (resync); err_sticky<=1.
// - Overflow during EMIT: the pending event is kept.
// - Simultaneous F0 after E0 (E0 F0 xx) -> one event, ext=1, break=1.
// - Repeated prefixes are idempotent.
// CONFIGURATION
// - Macro REPEAT_FILTER_EN.
// - Defined: hold last_make={ext,code} plus a last_valid bit.
//   - A make matching last_make while last_valid is consumed silently: no event, straight to IDLE.
//   - A break of the same key clears last_valid.
//   - A different make replaces last_make.
//   - Reset and overflow clear last_valid.
// - Undefined: every make byte, including typematic repeats, produces an event; logic absent.
// TESTING
// - 1C pushed, evt_ready=1 -> one pulse of evt_valid: code=1C ext=0 break=0; kb_rdn low exactly 1 cycle; evt_valid at N+4.
// - E0 F0 75 -> code=75 ext=1 break=1; 3 pops, 1 event.
// - E1 14 77 E1 F0 14 F0 77 -> single event code=77 ext=1 break=0; 8 pops.
// - AA, FA, then 00 -> no events; err_sticky=1 after 00.
// - 29 with evt_ready=0 for 10 cycles while 2A is queued -> event 29 held stable; then 2A follows; no byte lost.
// - F0 then idle for PREFIX_TIMEOUT cycles, then 1C -> make event 1C, break=0.
// - REPEAT_FILTER_EN: 1C 1C 1C F0 1C 1C -> events make1C, break1C, make1C only.

Source files
------------

// File: rtl/ps2_scancode_ctrl_if.sv
// ps2_scancode_ctrl_if: bundles the receiver-FIFO handshake (kb_*) and the
// key-event port (evt_*, err_sticky) of ps2_scancode_ctrl.
// master = the scancode controller, slave = its environment (FIFO + consumer).
interface ps2_scancode_ctrl_if;
    logic       kb_ready;
    logic [7:0] kb_data;
    logic       kb_overflow;
    logic       kb_rdn;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       err_sticky;

    modport master (
        input  kb_ready, kb_data, kb_overflow, evt_ready,
        output kb_rdn, evt_valid, evt_code, evt_ext, evt_break, err_sticky
    );

    modport slave (
        output kb_ready, kb_data, kb_overflow, evt_ready,
        input  kb_rdn, evt_valid, evt_code, evt_ext, evt_break, err_sticky
    );
endinterface

// File: rtl/ps2_scancode_ctrl.sv
// ps2_scancode_ctrl: pops PS/2 set-2 bytes from the keyboard receiver FIFO,
// folds E0/F0/E1 prefixes into a single key event and presents it on a
// valid/ready port. Protocol bytes (AA/FA/EE/FE) are dropped, 00/FF and
// FIFO overflow raise err_sticky. A pending prefix expires after
// PREFIX_TIMEOUT idle cycles. The E1 Pause sequence is reported as a single
// make event code 77, ext=1.
// Optional feature: define REPEAT_FILTER_EN to suppress typematic repeats
// (a make of the key that was last pressed and not yet released).
// Synchronous active-low reset clrn; single clock clk.
module ps2_scancode_ctrl #(
    parameter int unsigned PREFIX_TIMEOUT = 2_500_000,
    parameter int unsigned PAUSE_LEN      = 7
) (
    input  logic                clk,
    input  logic                clrn,
    ps2_scancode_ctrl_if.master bus
);

    localparam int unsigned TW = $clog2(PREFIX_TIMEOUT + 1);
    localparam int unsigned SW = $clog2(PAUSE_LEN + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(PREFIX_TIMEOUT - 1);

    localparam logic [7:0] B_EXT    = 8'hE0;
    localparam logic [7:0] B_BRK    = 8'hF0;
    localparam logic [7:0] B_PAUSE  = 8'hE1;
    localparam logic [7:0] B_BAT    = 8'hAA;
    localparam logic [7:0] B_ACK    = 8'hFA;
    localparam logic [7:0] B_ECHO   = 8'hEE;
    localparam logic [7:0] B_RESEND = 8'hFE;
    localparam logic [7:0] B_ERR0   = 8'h00;
    localparam logic [7:0] B_ERR1   = 8'hFF;
    localparam logic [7:0] PAUSE_CODE = 8'h77;

    typedef enum logic [2:0] {IDLE, POP, GAP, DECODE, EMIT} state_t;

    state_t        state_reg;
    logic [7:0]    byte_q_reg;
    logic          ext_f_reg;
    logic          brk_f_reg;
    logic [SW-1:0] skip_cnt_reg;
    logic [TW-1:0] timer_reg;
    logic          ovf_q_reg;

    logic          kb_rdn_reg;
    logic          evt_valid_reg;
    logic [7:0]    evt_code_reg;
    logic          evt_ext_reg;
    logic          evt_break_reg;
    logic          err_sticky_reg;

    logic byte_is_drop;
    logic byte_is_err;
    logic byte_is_code;
    logic pop_now;
    logic timer_run;
    logic timer_expire;
    logic ovf_rise;
    logic code_accept;
    logic repeat_suppress;

    assign bus.kb_rdn     = kb_rdn_reg;
    assign bus.evt_valid  = evt_valid_reg;
    assign bus.evt_code   = evt_code_reg;
    assign bus.evt_ext    = evt_ext_reg;
    assign bus.evt_break  = evt_break_reg;
    assign bus.err_sticky = err_sticky_reg;

    // Classify the byte currently held for decoding.
    always_comb begin
        byte_is_drop = (byte_q_reg == B_BAT) || (byte_q_reg == B_ACK) ||
                       (byte_q_reg == B_ECHO) || (byte_q_reg == B_RESEND);
        byte_is_err  = (byte_q_reg == B_ERR0) || (byte_q_reg == B_ERR1);
        byte_is_code = !byte_is_drop && !byte_is_err &&
                       (byte_q_reg != B_EXT) && (byte_q_reg != B_BRK) &&
                       (byte_q_reg != B_PAUSE);
    end

    assign pop_now      = (state_reg == IDLE) && bus.kb_ready && !evt_valid_reg;
    assign timer_run    = (ext_f_reg || brk_f_reg) && (state_reg == IDLE) && !bus.kb_ready;
    assign timer_expire = timer_run && (timer_reg == TIMER_LAST);
    assign ovf_rise     = bus.kb_overflow && !ovf_q_reg;
    assign code_accept  = (state_reg == DECODE) && (skip_cnt_reg == '0) && byte_is_code;

`ifdef REPEAT_FILTER_EN
    logic [8:0] last_make_reg;
    logic       last_valid_reg;
    logic       same_key;

    assign same_key        = (last_make_reg == {ext_f_reg, byte_q_reg});
    assign repeat_suppress = !brk_f_reg && last_valid_reg && same_key;

    // Track the most recently pressed key so its typematic repeats can be swallowed.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            last_make_reg  <= '0;
            last_valid_reg <= 1'b0;
        end else if (ovf_rise) begin
            last_valid_reg <= 1'b0;
        end else if (code_accept) begin
            if (brk_f_reg) begin
                if (same_key) begin
                    last_valid_reg <= 1'b0;
                end
            end else if (!repeat_suppress) begin
                last_make_reg  <= {ext_f_reg, byte_q_reg};
                last_valid_reg <= 1'b1;
            end
        end
    end
`else
    assign repeat_suppress = 1'b0;
`endif

    // Main sequencer: pop handshake, prefix folding, event hand-off, timeout and overflow resync.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_reg      <= IDLE;
            byte_q_reg     <= '0;
            ext_f_reg      <= 1'b0;
            brk_f_reg      <= 1'b0;
            skip_cnt_reg   <= '0;
            timer_reg      <= '0;
            // A level already high during reset is not treated as a new overflow.
            ovf_q_reg      <= bus.kb_overflow;
            kb_rdn_reg     <= 1'b1;
            evt_valid_reg  <= 1'b0;
            evt_code_reg   <= '0;
            evt_ext_reg    <= 1'b0;
            evt_break_reg  <= 1'b0;
            err_sticky_reg <= 1'b0;
        end else begin
            ovf_q_reg <= bus.kb_overflow;

            if (pop_now) begin
                timer_reg <= '0;
            end else if (timer_run) begin
                if (timer_reg == TIMER_LAST) begin
                    timer_reg <= '0;
                end else begin
                    timer_reg <= timer_reg + TW'(1);
                end
            end

            case (state_reg)
                IDLE: begin
                    if (pop_now) begin
                        byte_q_reg <= bus.kb_data;
                        kb_rdn_reg <= 1'b0;
                        state_reg  <= POP;
                    end else if (timer_expire) begin
                        ext_f_reg <= 1'b0;
                        brk_f_reg <= 1'b0;
                    end
                end

                POP: begin
                    kb_rdn_reg <= 1'b1;
                    state_reg  <= GAP;
                end

                // Dead cycle so kb_ready reflects the receiver's advanced read pointer.
                GAP: begin
                    state_reg <= DECODE;
                end

                DECODE: begin
                    if (skip_cnt_reg != '0) begin
                        skip_cnt_reg <= skip_cnt_reg - SW'(1);
                        if (skip_cnt_reg == SW'(1)) begin
                            evt_code_reg  <= PAUSE_CODE;
                            evt_ext_reg   <= 1'b1;
                            evt_break_reg <= 1'b0;
                            evt_valid_reg <= 1'b1;
                            state_reg     <= EMIT;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else if (byte_q_reg == B_EXT) begin
                        ext_f_reg <= 1'b1;
                        state_reg <= IDLE;
                    end else if (byte_q_reg == B_BRK) begin
                        brk_f_reg <= 1'b1;
                        state_reg <= IDLE;
                    end else if (byte_q_reg == B_PAUSE) begin
                        skip_cnt_reg <= SW'(PAUSE_LEN);
                        ext_f_reg    <= 1'b0;
                        brk_f_reg    <= 1'b0;
                        state_reg    <= IDLE;
                    end else if (byte_is_drop) begin
                        ext_f_reg <= 1'b0;
                        brk_f_reg <= 1'b0;
                        state_reg <= IDLE;
                    end else if (byte_is_err) begin
                        ext_f_reg      <= 1'b0;
                        brk_f_reg      <= 1'b0;
                        err_sticky_reg <= 1'b1;
                        state_reg      <= IDLE;
                    end else begin
                        ext_f_reg <= 1'b0;
                        brk_f_reg <= 1'b0;
                        if (repeat_suppress) begin
                            state_reg <= IDLE;
                        end else begin
                            evt_code_reg  <= byte_q_reg;
                            evt_ext_reg   <= ext_f_reg;
                            evt_break_reg <= brk_f_reg;
                            evt_valid_reg <= 1'b1;
                            state_reg     <= EMIT;
                        end
                    end
                end

                EMIT: begin
                    if (evt_valid_reg && bus.evt_ready) begin
                        evt_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase

            // Overflow resynchronises the prefix decoder; an event already presented is kept.
            if (ovf_rise) begin
                ext_f_reg      <= 1'b0;
                brk_f_reg      <= 1'b0;
                skip_cnt_reg   <= '0;
                err_sticky_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_ctrl.sv
// tb_ps2_scancode_ctrl: table-driven vectors, hand-written corner sequences
// and randomized byte streams checked against a byte-stream reference model.
module tb_ps2_scancode_ctrl;

    localparam int TMO = 16;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } evt_t;

    typedef struct {
        int          len;
        logic [31:0] seq;      // first byte in [31:24]
        int          n_evt;
        logic [7:0]  code;
        logic        ext;
        logic        brk;
        logic        err;
    } vec_t;

    logic clk;
    logic clrn;
    ps2_scancode_ctrl_if bus ();

    ps2_scancode_ctrl #(.PREFIX_TIMEOUT(TMO), .PAUSE_LEN(7)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   vectors;
    int   miscompares;
    int   rdn_low_cnt;
    int   rdn_double;
    int   stable_err;
    int   ready_mode;          // 0 = low, 1 = high, 2 = random
    logic [7:0] fifo_q[$];
    evt_t rx_q[$];
    evt_t exp_q[$];
    logic [7:0] mdl_in[$];
    logic exp_err;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Receiver FIFO model: pops on an edge where kb_rdn was low.
    initial begin
        logic pop_pend;
        bus.kb_ready = 1'b0;
        bus.kb_data  = 8'h00;
        forever begin
            @(negedge clk);
            pop_pend = (bus.kb_rdn === 1'b0);
            @(posedge clk);
            #1;
            if (pop_pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
            bus.kb_ready = (fifo_q.size() > 0);
            bus.kb_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
        end
    end

    // Consumer ready driver.
    initial begin
        bus.evt_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.evt_ready = 1'b0;
                1:       bus.evt_ready = 1'b1;
                default: bus.evt_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: collects accepted events, counts pops, checks stall stability.
    initial begin
        logic held_v;
        evt_t held_e;
        logic prev_rdn_low;
        held_v = 1'b0;
        held_e = '0;
        prev_rdn_low = 1'b0;
        forever begin
            @(negedge clk);
            if (clrn !== 1'b1) begin
                held_v = 1'b0;
                prev_rdn_low = 1'b0;
            end else begin
                if (bus.kb_rdn === 1'b0) begin
                    rdn_low_cnt++;
                    if (prev_rdn_low) rdn_double++;
                end
                prev_rdn_low = (bus.kb_rdn === 1'b0);
                if (held_v && (!bus.evt_valid ||
                    held_e != {bus.evt_code, bus.evt_ext, bus.evt_break}))
                    stable_err++;
                if (bus.evt_valid && bus.evt_ready)
                    rx_q.push_back({bus.evt_code, bus.evt_ext, bus.evt_break});
                held_v = bus.evt_valid && !bus.evt_ready;
                held_e = {bus.evt_code, bus.evt_ext, bus.evt_break};
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        clrn = 1'b0;
        fifo_q.delete();
        repeat (3) @(posedge clk);
        #1;
        clrn = 1'b1;
        rx_q.delete();
        rdn_low_cnt = 0;
        rdn_double = 0;
    endtask

    task automatic wait_quiet();
        int q = 0;
        int n = 0;
        while (q < 8 && n < 5000) begin
            @(negedge clk);
            n++;
            if (fifo_q.size() == 0 && !bus.kb_ready && bus.kb_rdn && !bus.evt_valid) q++;
            else q = 0;
        end
        if (q < 8) begin
            vectors++;
            miscompares++;
            $display("FAIL quiet_timeout: got busy, expected idle within 5000 cycles");
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.evt_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_valid", int'(bus.evt_valid), 1);
    endtask

    task automatic pulse_ovf();
        @(posedge clk);
        #1 bus.kb_overflow = 1'b1;
        @(posedge clk);
        #1 bus.kb_overflow = 1'b0;
    endtask

    // Reference model over a whole byte stream (from a freshly reset controller).
    task automatic run_model();
        bit e = 0;
        bit b = 0;
        int skip = 0;
        bit lv = 0;
        logic [8:0] lm = '0;
        exp_q.delete();
        exp_err = 1'b0;
        foreach (mdl_in[i]) begin
            logic [7:0] x = mdl_in[i];
            if (skip > 0) begin
                skip--;
                if (skip == 0) exp_q.push_back({8'h77, 1'b1, 1'b0});
            end else if (x == 8'hE0) e = 1;
            else if (x == 8'hF0) b = 1;
            else if (x == 8'hE1) begin skip = 7; e = 0; b = 0; end
            else if (x == 8'hAA || x == 8'hFA || x == 8'hEE || x == 8'hFE) begin e = 0; b = 0; end
            else if (x == 8'h00 || x == 8'hFF) begin e = 0; b = 0; exp_err = 1'b1; end
            else begin
                bit emit = 1;
`ifdef REPEAT_FILTER_EN
                if (!b && lv && lm == {e, x}) emit = 0;
                else if (b && lm == {e, x}) lv = 0;
                else if (!b) begin lm = {e, x}; lv = 1; end
`endif
                if (emit) exp_q.push_back({x, e, b});
                e = 0;
                b = 0;
            end
        end
        if (lv && lm == 9'h1FF) exp_err = 1'b1; // unreachable key value; keeps lv/lm referenced
    endtask

    task automatic check_events(input string tag);
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_evt%0d", tag, i), int'(rx_q[i]), int'(exp_q[i]));
        end
        check({tag, "_err"}, int'(bus.err_sticky), int'(exp_err));
    endtask

    task automatic run_stream(input string tag);
        do_reset();
        run_model();
        foreach (mdl_in[i]) fifo_q.push_back(mdl_in[i]);
        wait_quiet();
        check_events(tag);
    endtask

    vec_t vecs[12];

    initial begin
        vectors = 0;
        miscompares = 0;
        rdn_low_cnt = 0;
        rdn_double = 0;
        stable_err = 0;
        ready_mode = 1;
        clrn = 1'b0;
        bus.kb_overflow = 1'b0;

        vecs[0]  = '{1, 32'h1C000000, 1, 8'h1C, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{2, 32'hE0750000, 1, 8'h75, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{2, 32'hF0750000, 1, 8'h75, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{3, 32'hE0F07500, 1, 8'h75, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{3, 32'hF0E07500, 1, 8'h75, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{4, 32'hE0E0F01C, 1, 8'h1C, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{3, 32'hAAFA0000, 0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1, 32'hFF000000, 0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{2, 32'hEEFE0000, 0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{3, 32'hF0AA1C00, 1, 8'h1C, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{3, 32'hE0FA5A00, 1, 8'h5A, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1, 32'h83000000, 1, 8'h83, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_kb_rdn", int'(bus.kb_rdn), 1);
        check("rst_evt_valid", int'(bus.evt_valid), 0);
        check("rst_evt_code", int'(bus.evt_code), 0);
        check("rst_evt_ext", int'(bus.evt_ext), 0);
        check("rst_evt_break", int'(bus.evt_break), 0);
        check("rst_err", int'(bus.err_sticky), 0);

        // Table-driven vectors
        foreach (vecs[v]) begin
            logic [31:0] s;
            do_reset();
            s = vecs[v].seq;
            for (int k = 0; k < vecs[v].len; k++) fifo_q.push_back(s[31-8*k -: 8]);
            wait_quiet();
            check($sformatf("vec%0d_count", v), rx_q.size(), vecs[v].n_evt);
            if (rx_q.size() == 1 && vecs[v].n_evt == 1)
                check($sformatf("vec%0d_evt", v), int'(rx_q[0]),
                      int'({vecs[v].code, vecs[v].ext, vecs[v].brk}));
            check($sformatf("vec%0d_err", v), int'(bus.err_sticky), int'(vecs[v].err));
            check($sformatf("vec%0d_pops", v), rdn_low_cnt, vecs[v].len);
        end

        // Latency and single-cycle pop strobe
        begin
            int n = 0;
            int lat = 0;
            do_reset();
            fifo_q.push_back(8'h1C);
            while (!bus.kb_ready && n < 20) begin @(negedge clk); n++; end
            while (!bus.evt_valid && lat < 20) begin @(negedge clk); lat++; end
            check("latency", lat, 4);
            wait_quiet();
            check("lat_pops", rdn_low_cnt, 1);
            check("lat_rdn_width", rdn_double, 0);
            check("lat_count", rx_q.size(), 1);
        end

        // Pause sequence
        mdl_in = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        run_stream("pause");
        check("pause_evt_const", (rx_q.size() == 1) ? int'(rx_q[0]) : -1, int'({8'h77, 1'b1, 1'b0}));
        check("pause_pops", rdn_low_cnt, 8);

        // Stall: event 29 held while 2A waits in the FIFO
        do_reset();
        ready_mode = 0;
        fifo_q.push_back(8'h29);
        fifo_q.push_back(8'h2A);
        wait_valid();
        repeat (10) @(negedge clk);
        check("stall_valid", int'(bus.evt_valid), 1);
        check("stall_code", int'(bus.evt_code), 8'h29);
        check("stall_fifo_left", fifo_q.size(), 1);
        ready_mode = 1;
        wait_quiet();
        check("stall_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("stall_first", int'(rx_q[0]), int'({8'h29, 1'b0, 1'b0}));
            check("stall_second", int'(rx_q[1]), int'({8'h2A, 1'b0, 1'b0}));
        end

        // Prefix timeout: short gap keeps F0, long gap drops it
        do_reset();
        fifo_q.push_back(8'hF0);
        repeat (8) @(negedge clk);
        fifo_q.push_back(8'h1C);
        wait_quiet();
        check("tmo_short", (rx_q.size() == 1) ? int'(rx_q[0]) : -1, int'({8'h1C, 1'b0, 1'b1}));
        do_reset();
        fifo_q.push_back(8'hF0);
        repeat (TMO + 24) @(negedge clk);
        fifo_q.push_back(8'h1C);
        wait_quiet();
        check("tmo_long", (rx_q.size() == 1) ? int'(rx_q[0]) : -1, int'({8'h1C, 1'b0, 1'b0}));

        // Overflow clears pending prefix and sets err_sticky
        do_reset();
        fifo_q.push_back(8'hE0);
        wait_quiet();
        pulse_ovf();
        fifo_q.push_back(8'h75);
        wait_quiet();
        check("ovf_evt", (rx_q.size() == 1) ? int'(rx_q[0]) : -1, int'({8'h75, 1'b0, 1'b0}));
        check("ovf_err", int'(bus.err_sticky), 1);

        // Overflow during EMIT keeps the event; reset during EMIT drops it
        do_reset();
        ready_mode = 0;
        fifo_q.push_back(8'h1C);
        wait_valid();
        pulse_ovf();
        @(negedge clk);
        check("ovf_emit_valid", int'(bus.evt_valid), 1);
        check("ovf_emit_code", int'(bus.evt_code), 8'h1C);
        do_reset();
        @(negedge clk);
        check("rst_emit_valid", int'(bus.evt_valid), 0);
        check("rst_emit_err", int'(bus.err_sticky), 0);
        ready_mode = 1;

`ifdef REPEAT_FILTER_EN
        mdl_in = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
        run_stream("repeat");
        check("repeat_count_const", rx_q.size(), 3);
`endif

        // Randomized streams against the reference model
        ready_mode = 2;
        for (int batch = 0; batch < 8; batch++) begin
            mdl_in.delete();
            for (int i = 0; i < 40; i++) begin
                int r = $urandom_range(0, 99);
                logic [7:0] b;
                if (r < 12) b = 8'hE0;
                else if (r < 24) b = 8'hF0;
                else if (r < 26) b = 8'hE1;
                else if (r < 27) b = 8'hAA;
                else if (r < 28) b = 8'hFA;
                else if (r < 29) b = 8'hEE;
                else if (r < 30) b = 8'hFE;
                else if (r < 31) b = 8'h00;
                else if (r < 32) b = 8'hFF;
                else if (r < 40) b = 8'h1C;
                else b = 8'($urandom_range(1, 127));
                mdl_in.push_back(b);
            end
            run_stream($sformatf("rand%0d", batch));
        end
        ready_mode = 1;

        check("stall_stability", stable_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
